guess_checker: RTL and testbench
================================

Name: guess_checker

Overview:
Game-logic stage directly downstream of the random answer generator. It latches the packed answer word when the generator's `write_enable` pulses, and collects a player guess one digit at a time. On submit it scores the guess sequentially as strikes (right digit, right position) and balls (right digit, wrong position, repeat-aware). The result goes to the display/score logic.

Parameters:
N_DIGITS, 4, number of answer/guess digits used (1..8); digit i is taken from `rand[4*i+3:4*i]`
MAX_ATTEMPTS, 255, saturation value of the attempt counter (fits 8 bits)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
rand  input  32  packed answer from generator, 8 nibbles, legal digit values 1..8
write_enable  input  1  one-cycle pulse: load new answer from `rand`
digit_in  input  4  guess digit, legal values 1..8
digit_valid  input  1  one-cycle strobe: append `digit_in` to the guess
submit  input  1  one-cycle strobe: score the current guess
answer_loaded  output  1  a valid answer is held
guess_count  output  4  digits entered so far (0..N_DIGITS)
busy  output  1  scoring in progress
result_valid  output  1  one-cycle pulse: `strikes`/`balls` updated
strikes  output  4  strike count of the last scored guess
balls  output  4  ball count of the last scored guess
solved  output  1  last scored guess had strikes == N_DIGITS
attempts  output  8  number of scored guesses since the last answer load, saturating

Behaviour:
- Reset (`rst_n`=0, async): state NO_ANS. All outputs 0. Answer/guess registers cleared. Pending-load flag cleared. Reset mid-scoring aborts the scoring; no `result_valid` is produced.
- States: NO_ANS, ENTER, STRIKE, MATCH, REPORT.
- Answer load, in NO_ANS or ENTER:
  - `write_enable` latches `rand[4*N_DIGITS-1:0]`.
  - Clears the guess, `guess_count`, `attempts`, `solved`, `strikes`, `balls`.
  - Sets `answer_loaded`=1 and moves to ENTER.
- Load while busy: `write_enable` during STRIKE, MATCH or REPORT sets a pending flag. The load is applied from the stored `rand` copy in the cycle after REPORT, so it is never lost. A second pulse while pending overwrites the stored copy.
- Digit entry, ENTER only:
  - `digit_valid` with `digit_in` in 1..8 and `guess_count` < N_DIGITS writes guess position `guess_count` (first digit = position 0, compared against `rand[3:0]`), then increments `guess_count`.
  - Digits 0 or 9..15 are ignored.
  - Digits arriving when `guess_count` == N_DIGITS are ignored.
  - `digit_valid` in other states is ignored.
- Submit:
  - Accepted only in ENTER with `guess_count` == N_DIGITS and `solved`=0; otherwise ignored.
  - `submit` and `digit_valid` in the same cycle: the digit is processed first, and submit is evaluated against the pre-update count.
  - Accepted submit moves to STRIKE and raises `busy` from the next cycle.
- STRIKE: N_DIGITS cycles. Cycle i adds 1 to the internal strike accumulator when answer[i] == guess[i].
- MATCH: 8 cycles, value v = 1..8. Each cycle adds min(count of v in answer, count of v in guess) to the total-match accumulator. The counts are combinational over the stored registers.
- REPORT: 1 cycle.
  - `strikes` = strike accumulator; `balls` = total − strikes.
  - `result_valid`=1; `attempts` += 1, saturating at MAX_ATTEMPTS.
  - `solved` = (strikes == N_DIGITS).
  - `guess_count` is cleared.
  - Next state is ENTER, or the load action if the pending flag is set.
- Latency: accepted submit at edge T gives `result_valid` high in cycle T+N_DIGITS+8+1. `busy` is high for all STRIKE/MATCH/REPORT cycles.
- Widths: `strikes` + `balls` ≤ N_DIGITS always. Accumulators are 4 bits.
- `strikes`, `balls` and `solved` hold their values until the next REPORT or answer load.

Test Plan:
1. Reset, then `write_enable` with `rand`=32'h00001234 → `answer_loaded`=1, answer positions 4,3,2,1. Enter 4,3,2,1 and submit → `result_valid` exactly 13 cycles later; `strikes`=4, `balls`=0, `solved`=1, `attempts`=1. A further submit is ignored.
2. Same answer, guess 3,4,2,1 → `strikes`=2, `balls`=2, `solved`=0. Guess 5,6,7,8 → `strikes`=0, `balls`=0, `attempts`=2.
3. Repeat handling: `rand`=32'h00001111, guess 1,2,2,2 → `strikes`=1, `balls`=0. `rand`=32'h00001122 (positions 2,2,1,1), guess 1,1,2,2 → `strikes`=0, `balls`=4.
4. Entry filtering: digits 0, 9, 3 → `guess_count`=1. Submit with 3 digits → no `busy`. A 5th digit after 4 is ignored.
5. `write_enable` with `rand`=32'h00008765 during MATCH → the current result still reports against the old answer. The next cycle reloads: `attempts`=0, `guess_count`=0, new answer 5,6,7,8.
6. `rst_n` low mid-STRIKE → all outputs 0 immediately, no `result_valid`, state NO_ANS. Digits are ignored until `write_enable`.

Source files
------------

// File: rtl/guess_checker.sv
// guess_checker: holds the answer word from the random generator, collects a
// player guess one digit at a time and scores it as strikes and balls over a
// fixed number of cycles (N_DIGITS strike cycles, 8 match cycles, 1 report).
//
// Handshake: write_enable, digit_valid and submit are single-cycle strobes with
// no back-pressure. A strobe is consumed on the rising edge where it is high;
// if the current state cannot use it, it is dropped (except write_enable, which
// is parked in a pending slot while scoring is in progress and applied later).
//
// `rand` is a reserved word in SystemVerilog, so the answer input is rand_word.
module guess_checker #(
  parameter int N_DIGITS     = 4,
  parameter int MAX_ATTEMPTS = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rand_word,
  input  logic        write_enable,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  input  logic        submit,
  output logic        answer_loaded,
  output logic [3:0]  guess_count,
  output logic        busy,
  output logic        result_valid,
  output logic [3:0]  strikes,
  output logic [3:0]  balls,
  output logic        solved,
  output logic [7:0]  attempts,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    NO_ANS = 3'd0,
    ENTER  = 3'd1,
    STRIKE = 3'd2,
    MATCH  = 3'd3,
    REPORT = 3'd4
  } state_t;

  localparam logic [3:0] FULL_COUNT = 4'(N_DIGITS);
  localparam logic [2:0] LAST_POS   = 3'(N_DIGITS - 1);
  localparam logic [2:0] LAST_VAL  = 3'd7;
  localparam logic [7:0] ATT_MAX    = 8'(MAX_ATTEMPTS);

  state_t      state_q;
  state_t      state_d;

  // Digit storage is always 8 deep so a 3-bit position index fits exactly;
  // entries at or above N_DIGITS stay zero and are never scored.
  logic [3:0]  ans_q   [8];
  logic [3:0]  guess_q [8];

  logic        pend_q;
  logic [31:0] pend_word_q;

  logic [2:0]  idx_q;
  logic [3:0]  strike_acc_q;
  logic [3:0]  match_acc_q;

  logic        load_live;
  logic        load_pend;
  logic        do_load;
  logic [31:0] load_word;
  logic        digit_legal;
  logic        digit_ok;
  logic        submit_ok;
  logic        strike_hit;
  logic [3:0]  match_val;
  logic [3:0]  cnt_ans;
  logic [3:0]  cnt_guess;
  logic [3:0]  match_min;

  assign busy      = (state_q == STRIKE) || (state_q == MATCH) || (state_q == REPORT);
  assign state_dbg = state_q;

  // Decode which strobe actions take effect this cycle. A live load beats a
  // parked one because it carries the newer answer; any load wins over entry.
  always_comb begin
    load_live   = write_enable && ((state_q == NO_ANS) || (state_q == ENTER));
    load_pend   = pend_q && (state_q == ENTER) && !write_enable;
    do_load     = load_live || load_pend;
    load_word   = load_live ? rand_word : pend_word_q;
    digit_legal = (digit_in >= 4'd1) && (digit_in <= 4'd8);
    digit_ok    = (state_q == ENTER) && !do_load && digit_valid && digit_legal &&
                  (guess_count < FULL_COUNT);
    // Submit looks at the count before any same-cycle digit lands.
    submit_ok   = (state_q == ENTER) && !do_load && submit &&
                  (guess_count == FULL_COUNT) && !solved;
  end

  // Per-cycle scoring terms: positional equality for STRIKE, and for MATCH the
  // smaller of the occurrence counts of value idx+1 in answer and guess.
  always_comb begin
    strike_hit = (ans_q[idx_q] == guess_q[idx_q]);
    match_val  = {1'b0, idx_q} + 4'd1;
    cnt_ans    = '0;
    cnt_guess  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (ans_q[i] == match_val) cnt_ans = cnt_ans + 4'd1;
      if (guess_q[i] == match_val) cnt_guess = cnt_guess + 4'd1;
    end
    match_min = (cnt_ans < cnt_guess) ? cnt_ans : cnt_guess;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NO_ANS;
    else        state_q <= state_d;
  end

  // Next-state logic. Loads keep or put the machine in ENTER.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NO_ANS: if (load_live) state_d = ENTER;
      ENTER:  if (submit_ok) state_d = STRIKE;
      STRIKE: if (idx_q == LAST_POS) state_d = MATCH;
      MATCH:  if (idx_q == LAST_VAL) state_d = REPORT;
      REPORT: state_d = ENTER;
      default: state_d = NO_ANS;
    endcase
  end

  // Answer register: unpacked from the load word, nibble i to position i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) ans_q[i] <= '0;
    end else if (do_load) begin
      for (int i = 0; i < 8; i++) ans_q[i] <= (i < N_DIGITS) ? load_word[4*i +: 4] : 4'd0;
    end
  end

  // Guess register and digit counter. The counter is cleared after each
  // report so the player starts a fresh guess; stale digits get overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) guess_q[i] <= '0;
      guess_count <= '0;
    end else if (do_load) begin
      for (int i = 0; i < 8; i++) guess_q[i] <= '0;
      guess_count <= '0;
    end else if (state_q == REPORT) begin
      guess_count <= '0;
    end else if (digit_ok) begin
      guess_q[guess_count[2:0]] <= digit_in;
      guess_count <= guess_count + 4'd1;
    end
  end

  // Pending-load slot: captures write_enable seen while scoring; a later
  // pulse overwrites the stored word. Emptied when any load is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_word_q <= '0;
    end else if (write_enable && busy) begin
      pend_q      <= 1'b1;
      pend_word_q <= rand_word;
    end else if (do_load) begin
      pend_q      <= 1'b0;
    end
  end

  // Scoring sequencer: idx walks positions in STRIKE, then values-1 in MATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      strike_acc_q <= '0;
      match_acc_q  <= '0;
    end else if (submit_ok) begin
      idx_q        <= '0;
      strike_acc_q <= '0;
      match_acc_q  <= '0;
    end else if (state_q == STRIKE) begin
      if (strike_hit) strike_acc_q <= strike_acc_q + 4'd1;
      idx_q <= (idx_q == LAST_POS) ? 3'd0 : idx_q + 3'd1;
    end else if (state_q == MATCH) begin
      match_acc_q <= match_acc_q + match_min;
      idx_q       <= idx_q + 3'd1;
    end
  end

  // Result registers: published once per scored guess, cleared by a load,
  // otherwise held. result_valid is a single-cycle pulse after REPORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      answer_loaded <= 1'b0;
      result_valid  <= 1'b0;
      strikes       <= '0;
      balls         <= '0;
      solved        <= 1'b0;
      attempts      <= '0;
    end else begin
      result_valid <= 1'b0;
      if (do_load) begin
        answer_loaded <= 1'b1;
        strikes       <= '0;
        balls         <= '0;
        solved        <= 1'b0;
        attempts      <= '0;
      end else if (state_q == REPORT) begin
        result_valid <= 1'b1;
        strikes      <= strike_acc_q;
        balls        <= match_acc_q - strike_acc_q;
        solved       <= (strike_acc_q == FULL_COUNT);
        if (attempts != ATT_MAX) attempts <= attempts + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_guess_checker.sv
// Bench for guess_checker: directed scenarios plus randomized games scored
// against a greedy strike/ball reference model.
module tb_guess_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rand_word = '0;
  logic        write_enable = 1'b0;
  logic [3:0]  digit_in = '0;
  logic        digit_valid = 1'b0;
  logic        submit = 1'b0;
  logic        answer_loaded;
  logic [3:0]  guess_count;
  logic        busy;
  logic        result_valid;
  logic [3:0]  strikes;
  logic [3:0]  balls;
  logic        solved;
  logic [7:0]  attempts;
  logic [2:0]  state_dbg;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [7:0] exp_q[$];

  guess_checker #(.N_DIGITS(4), .MAX_ATTEMPTS(255)) dut (
    .clk(clk), .rst_n(rst_n), .rand_word(rand_word), .write_enable(write_enable),
    .digit_in(digit_in), .digit_valid(digit_valid), .submit(submit),
    .answer_loaded(answer_loaded), .guess_count(guess_count), .busy(busy),
    .result_valid(result_valid), .strikes(strikes), .balls(balls),
    .solved(solved), .attempts(attempts), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Reference model: strikes are equal positions; balls are found by pairing
  // each remaining guess digit with an unused remaining answer digit.
  function automatic void score(input logic [15:0] a, input logic [15:0] g,
                                output int s, output int b);
    bit used_a[4];
    bit used_g[4];
    s = 0;
    b = 0;
    for (int i = 0; i < 4; i++) begin
      used_a[i] = 1'b0;
      used_g[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] == g[4*i +: 4]) begin
        s++;
        used_a[i] = 1'b1;
        used_g[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!used_g[i]) begin
        for (int j = 0; j < 4; j++) begin
          if (!used_a[j] && a[4*j +: 4] == g[4*i +: 4]) begin
            b++;
            used_a[j] = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  // Driver tasks: strobes go high on a falling edge and drop on the next one.
  task automatic pulse_load(input logic [31:0] w);
    @(negedge clk);
    rand_word = w;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    @(negedge clk);
    digit_in = d;
    digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic enter_guess(input logic [15:0] g);
    for (int i = 0; i < 4; i++) enter_digit(g[4*i +: 4]);
  endtask

  task automatic submit_pulse();
    @(negedge clk);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
  endtask

  // Returns the number of rising edges from the accepting edge to result_valid.
  task automatic submit_wait(output int n);
    n = 0;
    submit_pulse();
    while (result_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    check_cnt++;
    if ({answer_loaded, guess_count, busy, result_valid, strikes, balls, solved, attempts} !== '0)
      $display("FAIL reset_outputs got %h want 0",
               {answer_loaded, guess_count, busy, result_valid, strikes, balls, solved, attempts});
    else pass_cnt++;
    check_cnt++;
    if (state_dbg !== 3'd0) $display("FAIL reset_state got %0d want 0", state_dbg);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact_match();
    int n;
    pulse_load(32'h0000_1234);
    check_cnt++;
    if (answer_loaded !== 1'b1) $display("FAIL t1_loaded got %0b want 1", answer_loaded);
    else pass_cnt++;
    enter_guess(16'h1234);
    check_cnt++;
    if (guess_count !== 4'd4) $display("FAIL t1_count got %0d want 4", guess_count);
    else pass_cnt++;
    submit_wait(n);
    check_cnt++;
    if (n !== 13) $display("FAIL t1_latency got %0d want 13", n);
    else pass_cnt++;
    check_cnt++;
    if ({strikes, balls, solved, attempts} !== {4'd4, 4'd0, 1'b1, 8'd1})
      $display("FAIL t1_result got s=%0d b=%0d solved=%0b att=%0d want s=4 b=0 solved=1 att=1",
               strikes, balls, solved, attempts);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (result_valid !== 1'b0) $display("FAIL t1_pulse got %0b want 0", result_valid);
    else pass_cnt++;
    enter_guess(16'h1234);
    submit_pulse();
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL t1_solved_submit_busy got %0b want 0", busy);
    else pass_cnt++;
    repeat (15) @(negedge clk);
    check_cnt++;
    if (attempts !== 8'd1) $display("FAIL t1_solved_attempts got %0d want 1", attempts);
    else pass_cnt++;
  endtask

  task automatic test_partial();
    int n, s, b;
    pulse_load(32'h0000_1234);
    enter_guess(16'h1243);
    submit_wait(n);
    score(16'h1234, 16'h1243, s, b);
    check_cnt++;
    if ({strikes, balls, solved, attempts} !== {4'(s), 4'(b), 1'b0, 8'd1})
      $display("FAIL t2_partial got s=%0d b=%0d solved=%0b att=%0d want s=%0d b=%0d solved=0 att=1",
               strikes, balls, solved, attempts, s, b);
    else pass_cnt++;
    enter_guess(16'h8765);
    submit_wait(n);
    score(16'h1234, 16'h8765, s, b);
    check_cnt++;
    if ({strikes, balls, attempts} !== {4'(s), 4'(b), 8'd2})
      $display("FAIL t2_miss got s=%0d b=%0d att=%0d want s=%0d b=%0d att=2",
               strikes, balls, attempts, s, b);
    else pass_cnt++;
  endtask

  task automatic test_repeats();
    int n, s, b;
    pulse_load(32'h0000_1111);
    enter_guess(16'h2221);
    submit_wait(n);
    score(16'h1111, 16'h2221, s, b);
    check_cnt++;
    if ({strikes, balls} !== {4'(s), 4'(b)})
      $display("FAIL t3_rep_a got s=%0d b=%0d want s=%0d b=%0d", strikes, balls, s, b);
    else pass_cnt++;
    pulse_load(32'h0000_1122);
    enter_guess(16'h2211);
    submit_wait(n);
    score(16'h1122, 16'h2211, s, b);
    check_cnt++;
    if ({strikes, balls} !== {4'(s), 4'(b)})
      $display("FAIL t3_rep_b got s=%0d b=%0d want s=%0d b=%0d", strikes, balls, s, b);
    else pass_cnt++;
  endtask

  task automatic test_entry_filter();
    int n, s, b;
    pulse_load(32'h0000_1234);
    enter_digit(4'd0);
    enter_digit(4'd9);
    enter_digit(4'd3);
    check_cnt++;
    if (guess_count !== 4'd1) $display("FAIL t4_filter_count got %0d want 1", guess_count);
    else pass_cnt++;
    enter_digit(4'd4);
    enter_digit(4'd2);
    submit_pulse();
    check_cnt++;
    if (busy !== 1'b0 || guess_count !== 4'd3)
      $display("FAIL t4_short_submit got busy=%0b cnt=%0d want busy=0 cnt=3", busy, guess_count);
    else pass_cnt++;
    enter_digit(4'd1);
    enter_digit(4'd7);
    check_cnt++;
    if (guess_count !== 4'd4) $display("FAIL t4_fifth_digit got %0d want 4", guess_count);
    else pass_cnt++;
    submit_wait(n);
    score(16'h1234, 16'h1243, s, b);
    check_cnt++;
    if ({strikes, balls} !== {4'(s), 4'(b)} || n !== 13)
      $display("FAIL t4_score got s=%0d b=%0d lat=%0d want s=%0d b=%0d lat=13", strikes, balls, n, s, b);
    else pass_cnt++;
  endtask

  task automatic test_load_while_busy();
    int n, s, b;
    pulse_load(32'h0000_1234);
    enter_guess(16'h8765);
    submit_pulse();
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n++;
    end
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL t5_busy got %0b want 1", busy);
    else pass_cnt++;
    rand_word = 32'h0000_8765;
    write_enable = 1'b1;
    @(negedge clk);
    n++;
    write_enable = 1'b0;
    rand_word = 32'h0;
    while (result_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    score(16'h1234, 16'h8765, s, b);
    check_cnt++;
    if ({strikes, balls, attempts} !== {4'(s), 4'(b), 8'd1} || n !== 13)
      $display("FAIL t5_old_answer got s=%0d b=%0d att=%0d lat=%0d want s=%0d b=%0d att=1 lat=13",
               strikes, balls, attempts, n, s, b);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({attempts, guess_count, strikes, answer_loaded} !== {8'd0, 4'd0, 4'd0, 1'b1})
      $display("FAIL t5_reload got att=%0d cnt=%0d s=%0d loaded=%0b want 0 0 0 1",
               attempts, guess_count, strikes, answer_loaded);
    else pass_cnt++;
    enter_guess(16'h8765);
    submit_wait(n);
    check_cnt++;
    if ({strikes, solved} !== {4'd4, 1'b1})
      $display("FAIL t5_new_answer got s=%0d solved=%0b want s=4 solved=1", strikes, solved);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_strike();
    int n;
    bit rv_seen;
    pulse_load(32'h0000_1234);
    enter_guess(16'h1234);
    submit_pulse();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({answer_loaded, guess_count, busy, result_valid, strikes, balls, solved, attempts, state_dbg} !== '0)
      $display("FAIL t6_async_reset got %h want 0",
               {answer_loaded, guess_count, busy, result_valid, strikes, balls, solved, attempts, state_dbg});
    else pass_cnt++;
    rv_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (result_valid === 1'b1) rv_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (result_valid === 1'b1) rv_seen = 1'b1;
    end
    check_cnt++;
    if (rv_seen !== 1'b0 || state_dbg !== 3'd0)
      $display("FAIL t6_abort got rv_seen=%0b state=%0d want 0 0", rv_seen, state_dbg);
    else pass_cnt++;
    enter_digit(4'd3);
    check_cnt++;
    if (guess_count !== 4'd0) $display("FAIL t6_digit_ignored got %0d want 0", guess_count);
    else pass_cnt++;
    pulse_load(32'h0000_1234);
    enter_guess(16'h1234);
    submit_wait(n);
    check_cnt++;
    if ({strikes, attempts} !== {4'd4, 8'd1} || n !== 13)
      $display("FAIL t6_after_reset got s=%0d att=%0d lat=%0d want s=4 att=1 lat=13", strikes, attempts, n);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int n, s, b;
    logic [31:0] w;
    logic [15:0] g;
    for (int it = 0; it < 15; it++) begin
      w = $urandom;
      for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(1, 8));
      pulse_load(w);
      for (int i = 0; i < 4; i++) begin
        g[4*i +: 4] = 4'($urandom_range(1, 8));
        if ($urandom_range(0, 3) == 0) enter_digit(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15)));
        enter_digit(g[4*i +: 4]);
      end
      submit_wait(n);
      score(w[15:0], g, s, b);
      check_cnt++;
      if ({strikes, balls, solved, attempts} !== {4'(s), 4'(b), (s == 4), 8'd1} || n !== 13)
        $display("FAIL rand_%0d ans=%h guess=%h got s=%0d b=%0d solved=%0b att=%0d lat=%0d want s=%0d b=%0d lat=13",
                 it, w[15:0], g, strikes, balls, solved, attempts, n, s, b);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int n, s, b;
    logic [31:0] w;
    logic [15:0] g;
    logic [7:0] exp;
    w = '0;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(1, 8));
    pulse_load(w);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) g[4*i +: 4] = 4'($urandom_range(1, 8));
      if (g == w[15:0]) g[3:0] = (g[3:0] == 4'd8) ? 4'd1 : g[3:0] + 4'd1;
      score(w[15:0], g, s, b);
      exp_q.push_back({4'(s), 4'(b)});
      enter_guess(g);
      submit_wait(n);
      exp = exp_q.pop_front();
      check_cnt++;
      if ({strikes, balls} !== exp || attempts !== 8'(k + 1) || n !== 13)
        $display("FAIL b2b_%0d got sb=%h att=%0d lat=%0d want sb=%h att=%0d lat=13",
                 k, {strikes, balls}, attempts, n, exp, k + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int n;
    pulse_load(32'h0000_1234);
    for (int k = 0; k < 256; k++) begin
      enter_guess(16'h8765);
      submit_wait(n);
      if (k == 253) begin
        check_cnt++;
        if (attempts !== 8'd254) $display("FAIL sat_254 got %0d want 254", attempts);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (attempts !== 8'd255) $display("FAIL sat_hold got %0d want 255", attempts);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_partial();
    test_repeats();
    test_entry_filter();
    test_load_while_busy();
    test_reset_mid_strike();
    test_random();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
